// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_rx -- 16x-oversampled 8N1 UART receiver.
//
// Consumes the baud generator's BCLK as an oversampling tick source. Each
// rising BCLK edge, seen in the CLK domain, is one tick. Frames are LSB
// first. A start bit must still be low at mid-bit, or it is dropped as a
// glitch. A low stop bit raises FRAME_ERR, and the receiver then waits for
// the line to return high before it can start another frame.
//
// Optional feature: define UART_RX_PARITY_EN to add one even-parity bit
// between the data and stop bits. Without the macro, PARITY_ERR is tied 0.
//
// Parameters:
//   DATA_BITS     data bits per frame (5..9)
//   OVERSAMPLING  BCLK ticks per bit, even and >= 4
//
// Ports:
//   CLK         receiver clock, all logic on its rising edge
//   RST         asynchronous active-high reset
//   BCLK        baud/oversampling clock, asynchronous to CLK
//   RXD         serial line, asynchronous, idles high
//   DATA_OUT    last good word, held until the next VALID
//   VALID       one-cycle pulse, DATA_OUT updated
//   FRAME_ERR   one-cycle pulse, stop bit sampled low
//   PARITY_ERR  one-cycle pulse, parity mismatch
//   BUSY        high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS    = 8,
    parameter int OVERSAMPLING = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 BCLK,
    input  logic                 RXD,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic                 VALID,
    output logic                 FRAME_ERR,
    output logic                 PARITY_ERR,
    output logic                 BUSY
);

    localparam int TW = $clog2(OVERSAMPLING) + 1;
    localparam int BW = $clog2(DATA_BITS) + 1;

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLING / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLING - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 armed;

    logic rxd_meta, rxd_s;
    logic bclk_meta, bclk_s, bclk_prev;
    logic tick;

`ifdef UART_RX_PARITY_EN
    logic par_bad;
`endif

    // Two-flop synchronizers. RXD flops reset to the idle (high) level so
    // that reset release cannot look like a start bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rxd_meta  <= 1'b1;
            rxd_s     <= 1'b1;
            bclk_meta <= 1'b0;
            bclk_s    <= 1'b0;
            bclk_prev <= 1'b0;
        end else begin
            rxd_meta  <= RXD;
            rxd_s     <= rxd_meta;
            bclk_meta <= BCLK;
            bclk_s    <= bclk_meta;
            bclk_prev <= bclk_s;
        end
    end

    assign tick = bclk_s & ~bclk_prev;

    // Receiver FSM. Pulse outputs default low every cycle. They are set on
    // the sampling tick, so each one is high for exactly the next cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            armed     <= 1'b0;
            DATA_OUT  <= '0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
            BUSY      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            PARITY_ERR <= 1'b0;
`endif
        end else begin
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
            PARITY_ERR <= 1'b0;
`endif
            if (tick) begin
                case (state)
                    // After reset, the line has to be seen high once before a
                    // low level counts as a start bit. This keeps a frame cut
                    // by reset from being picked up halfway through.
                    S_IDLE: begin
                        if (rxd_s) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            state    <= S_START;
                            tick_cnt <= '0;
                            BUSY     <= 1'b1;
                        end
                    end

                    S_START: begin
                        if (tick_cnt == TICK_HALF) begin
                            tick_cnt <= '0;
                            if (!rxd_s) begin
                                state   <= S_DATA;
                                bit_cnt <= '0;
                            end else begin
                                // Line is high again at mid-bit, so this was a glitch.
                                state <= S_IDLE;
                                BUSY  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_ONE;
                        end
                    end

                    S_DATA: begin
                        if (tick_cnt == TICK_FULL) begin
                            tick_cnt <= '0;
                            shreg    <= {rxd_s, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                                state   <= S_PARITY;
`else
                                state   <= S_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + BIT_ONE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_ONE;
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    // Even parity: data bits XOR parity bit must be 0.
                    S_PARITY: begin
                        if (tick_cnt == TICK_FULL) begin
                            tick_cnt <= '0;
                            par_bad  <= (^shreg) ^ rxd_s;
                            state    <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_ONE;
                        end
                    end
`endif

                    S_STOP: begin
                        if (tick_cnt == TICK_FULL) begin
                            tick_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            PARITY_ERR <= par_bad;
`endif
                            if (rxd_s) begin
                                DATA_OUT <= shreg;
                                VALID    <= 1'b1;
                                state    <= S_IDLE;
                                BUSY     <= 1'b0;
                            end else begin
                                FRAME_ERR <= 1'b1;
                                state     <= S_BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_ONE;
                        end
                    end

                    // Stay here while the line is held low, so that a break
                    // condition does not produce a string of frames.
                    S_BREAK: begin
                        if (rxd_s) begin
                            state <= S_IDLE;
                            BUSY  <= 1'b0;
                        end
                    end

                    default: begin
                        state    <= S_IDLE;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        BUSY     <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Randomized and directed bench for uart_rx. BCLK toggles every 3 CLK, so
// one bit is 96 CLK. The reference model predicts one event per frame from
// the frame contents alone. A monitor collects every pulse from the DUT,
// and the two queues are compared in order.
module tb_uart_rx;

    localparam int DW  = 8;
    localparam int BIT = 96;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bclk = 1'b0;
    logic          rxd = 1'b1;
    logic [DW-1:0] data_out;
    logic          valid, frame_err, parity_err, busy;

    int total = 0;
    int bad   = 0;
    int bcnt  = 0;

    logic [31:0]   obs_q[$];
    logic [31:0]   exp_q[$];
    logic [DW-1:0] last_good = '0;

    uart_rx #(.DATA_BITS(DW), .OVERSAMPLING(16)) dut (
        .CLK        (clk),
        .RST        (rst),
        .BCLK       (bclk),
        .RXD        (rxd),
        .DATA_OUT   (data_out),
        .VALID      (valid),
        .FRAME_ERR  (frame_err),
        .PARITY_ERR (parity_err),
        .BUSY       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bcnt == 2) begin
            bcnt <= 0;
            bclk <= ~bclk;
        end else begin
            bcnt <= bcnt + 1;
        end
    end

    // Monitor: one entry per cycle that carries any pulse.
    always @(negedge clk) begin
        if (valid || frame_err || parity_err)
            obs_q.push_back({21'd0, valid, frame_err, parity_err, data_out});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put_bit(input logic b);
        rxd = b;
        repeat (BIT) @(negedge clk);
    endtask

    // Sends one frame and records the event the receiver must report for it.
    // pok selects a correct even-parity bit; it only matters in the parity build.
    task automatic send_frame(input logic [DW-1:0] d, input logic stop, input logic pok);
        logic pe;
        pe = 1'b0;
        put_bit(1'b0);
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        for (int i = 0; i < DW; i++) put_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        put_bit(pok ? ^d : ~^d);
        pe = ~pok;
`endif
        put_bit(stop);
        if (stop) begin
            exp_q.push_back({21'd0, 1'b1, 1'b0, pe, d});
            last_good = d;
        end else begin
            exp_q.push_back({21'd0, 1'b0, 1'b1, pe, last_good});
        end
    endtask

    task automatic drain();
        int n;
        rxd = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        chk("evt_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("evt%0d", i), obs_q[i], exp_q[i]);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("data_hold", {24'd0, data_out}, {24'd0, last_good});
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          stop;
        logic [7:0]    v5a;

        repeat (4) @(negedge clk);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_pulses", {29'd0, valid, frame_err, parity_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (2 * BIT) @(negedge clk);

        // Clean frame
        send_frame(8'hA5, 1'b1, 1'b1);
        drain();

        // Short glitch: 30 CLK low is under half a bit
        rxd = 1'b0;
        repeat (30) @(negedge clk);
        rxd = 1'b1;
        drain();

        // Bad stop bit, then the line is held low for 3 more bits
        send_frame(8'h3C, 1'b0, 1'b1);
        repeat (3 * BIT) @(negedge clk);
        drain();

        // Back-to-back, zero idle
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h81, 1'b1, 1'b1);
        drain();

        // Reset in the middle of data bit 4 of 0x5A
        v5a = 8'h5A;
        put_bit(1'b0);
        for (int i = 0; i < 4; i++) put_bit(v5a[i]);
        rxd = v5a[4];
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", {24'd0, data_out}, 32'd0);
        chk("mid_rst_pulses", {29'd0, valid, frame_err, parity_err}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_good = '0;
        rxd = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        send_frame(8'h12, 1'b1, 1'b1);
        drain();

        // Parity directed case: wrong parity, then correct parity
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        drain();

        // Randomized frames with random gaps and occasional bad stop bits
        for (int k = 0; k < 16; k++) begin
            int gap;
            d    = DW'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            gap  = $urandom_range(0, 2);
            send_frame(d, stop, 1'($urandom_range(0, 1)));
            if (!stop && gap < 2) gap = 2;
            rxd = 1'b1;
            repeat (gap * BIT) @(negedge clk);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 16x-oversampled UART receiver. It consumes the BCLK output of the baud generator and the serial RXD line.
- Recovers 8N1 frames, LSB first, and presents each byte with a one-cycle valid pulse to the downstream logic on the CLK domain.
- Start bits are qualified at mid-bit, so line glitches shorter than half a bit are rejected.
- Stop-bit violations are flagged as framing errors.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- OVERSAMPLING, 16, BCLK ticks per bit period. Must be even and ≥ 4.

Ports:
- CLK  input  1  UART input clock. All logic is on its rising edge.
- RST  input  1  reset, asynchronous, active-high.
- BCLK  input  1  baud clock from the baud generator. Each rising edge, detected in the CLK domain, is one oversampling tick.
- RXD  input  1  serial line, asynchronous, idles high.
- DATA_OUT  output  DATA_BITS  last received word. Holds until the next VALID.
- VALID  output  1  one-CLK pulse: DATA_OUT updated with a good frame.
- FRAME_ERR  output  1  one-CLK pulse: stop bit sampled low.
- PARITY_ERR  output  1  one-CLK pulse: parity mismatch (see Optional Feature).
- BUSY  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE; all counters 0.
  - RXD synchronizer flops = 1; BCLK synchronizer and edge flops = 0.
  - DATA_OUT=0; VALID, FRAME_ERR, PARITY_ERR, BUSY = 0.
  - Reset mid-frame aborts the frame with no pulses.
  - After release, the receiver re-arms only on a fresh falling edge seen in IDLE.
- Synchronization:
  - RXD and BCLK each pass through a 2-FF synchronizer.
  - tick = sync_bclk & ~prev_bclk, one CLK wide.
  - All state progress happens only on CLK cycles where tick=1.
- tick_cnt: width $clog2(OVERSAMPLING) + 1. bit_cnt: width $clog2(DATA_BITS) + 1.
- IDLE:
  - On a tick with rxd_s=0 → START, tick_cnt=0.
- START:
  - Each tick increments tick_cnt.
  - On the tick where tick_cnt reaches OVERSAMPLING/2 − 1:
    - if rxd_s=0 → DATA, tick_cnt=0, bit_cnt=0;
    - else → IDLE (glitch rejected, no pulses).
- DATA:
  - Each tick increments tick_cnt.
  - At tick_cnt = OVERSAMPLING − 1 (mid-bit): shift rxd_s into the MSB of the shift register (shift right, so LSB arrives first), tick_cnt=0, bit_cnt++.
  - After DATA_BITS samples → STOP, or PARITY if the feature is enabled.
- STOP:
  - At tick_cnt = OVERSAMPLING − 1, sample rxd_s.
  - If 1: DATA_OUT ← shift register; VALID=1 for exactly the next CLK cycle; → IDLE.
  - If 0: FRAME_ERR=1 for one cycle; DATA_OUT unchanged; → BREAK.
- BREAK:
  - Wait for a tick with rxd_s=1, then → IDLE.
  - This prevents a held-low line from producing repeated frames.
- Output timing:
  - Pulse outputs are registered and assert on the CLK edge following the sampling tick.
  - There is no backpressure. Back-to-back frames overwrite DATA_OUT, and an unread byte is lost silently.
  - Minimum gap is zero: START may be entered on the first tick after returning to IDLE.
- Simultaneous events:
  - VALID and FRAME_ERR are mutually exclusive.
  - PARITY_ERR may coincide with VALID; in that case data is delivered and flagged.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state between DATA and STOP, one bit period, sampled at tick_cnt = OVERSAMPLING − 1.
  - Even parity: XOR of data bits and parity bit must be 0.
  - On mismatch, PARITY_ERR pulses together with the frame's VALID, or alone if the stop bit is also bad (FRAME_ERR then pulses as well).
- Undefined:
  - No PARITY state; the frame goes DATA → STOP.
  - PARITY_ERR is tied 0.

Test Plan:
- Setup: BCLK toggles every 3 CLK, giving a tick every 6 CLK and a bit of 96 CLK.
- Send 0xA5 (8N1), stop=1 → exactly one VALID pulse, DATA_OUT=0xA5, FRAME_ERR=0, BUSY high from start detection until VALID.
- Drive RXD low for 30 CLK (5 ticks, under half a bit), then high → no VALID; BUSY returns 0 and state is IDLE.
- Send 0x3C with stop bit=0, then hold RXD low for 3 bit times, then release → one FRAME_ERR pulse, no VALID, DATA_OUT keeps its previous value, no second frame while low.
- Send 0x00, 0xFF and 0x81 back-to-back with zero idle → three VALID pulses in order, DATA_OUT values match each frame.
- Assert RST for 2 CLK in the middle of bit 4 of 0x5A → outputs return to reset values immediately; the next clean frame 0x12 is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity bit=0 (wrong) → VALID with DATA_OUT=0x07 and PARITY_ERR in the same cycle. Resend 0x07 with parity bit=1 → PARITY_ERR=0.
